// File: rtl/timer_peripheral.sv
// Memory-mapped timer / LED / seven-segment / system-tick peripheral on the MEM-stage data bus.
// Optional: define TIMER_PRESCALE_EN to add a PRESCALE register (offset 0x18) and tick divider.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        IRQ,
    output logic [7:0]  led,
    output logic [11:0] ssd
);

    typedef enum logic [2:0] {
        SEL_TH       = 3'd0,
        SEL_TL       = 3'd1,
        SEL_TCON     = 3'd2,
        SEL_LED      = 3'd3,
        SEL_SSD      = 3'd4,
        SEL_SYSTICK  = 3'd5,
        SEL_PRESCALE = 3'd6,
        SEL_NONE     = 3'd7
    } reg_sel_t;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  led_q;
    logic [11:0] ssd_q;
    logic [31:0] systick;

    logic [31:0] offset;
    reg_sel_t    sel;
    logic        wr;
    logic        tick;
    logic        overflow;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale;
    logic [15:0] divider;
`endif

    // Address decode: only exact word-aligned offsets inside the map select a register
    always_comb begin
        offset = address - BASE_ADDR;
        sel    = SEL_NONE;
        if (offset[1:0] == 2'b00 && offset[31:5] == '0) begin
            case (offset[4:2])
                3'd0:    sel = SEL_TH;
                3'd1:    sel = SEL_TL;
                3'd2:    sel = SEL_TCON;
                3'd3:    sel = SEL_LED;
                3'd4:    sel = SEL_SSD;
                3'd5:    sel = SEL_SYSTICK;
`ifdef TIMER_PRESCALE_EN
                3'd6:    sel = SEL_PRESCALE;
`endif
                default: sel = SEL_NONE;
            endcase
        end
    end

    assign hit = (sel != SEL_NONE);
    assign wr  = MemWrite && hit;

`ifdef TIMER_PRESCALE_EN
    assign tick = tcon[0] && (divider == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            divider  <= '0;
        end else begin
            if (wr && sel == SEL_PRESCALE) begin
                prescale <= write_data[15:0];
            end
            if (!tcon[0] || (wr && sel == SEL_PRESCALE) || tick) begin
                divider <= '0;
            end else begin
                divider <= divider + 16'd1;
            end
        end
    end
`else
    assign tick = tcon[0];
`endif

    assign overflow = tick && (tl == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            th <= '0;
        end else if (wr && sel == SEL_TH) begin
            th <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tl <= '0;
        end else if (wr && sel == SEL_TL) begin
            tl <= write_data;
        end else if (overflow) begin
            tl <= th;
        end else if (tick) begin
            tl <= tl + 32'd1;
        end
    end

    // A store to TL on the overflow cycle replaces the wrap, so no interrupt is raised for it
    always_ff @(posedge clk) begin
        if (reset) begin
            tcon <= '0;
        end else if (wr && sel == SEL_TCON) begin
            tcon <= write_data[2:0];
        end else if (overflow && tcon[1] && !(wr && sel == SEL_TL)) begin
            tcon[2] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
            ssd_q <= '0;
        end else begin
            if (wr && sel == SEL_LED) begin
                led_q <= write_data[7:0];
            end
            if (wr && sel == SEL_SSD) begin
                ssd_q <= write_data[11:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    always_comb begin
        read_data = '0;
        if (MemRead) begin
            case (sel)
                SEL_TH:       read_data = th;
                SEL_TL:       read_data = tl;
                SEL_TCON:     read_data = {29'd0, tcon};
                SEL_LED:      read_data = {24'd0, led_q};
                SEL_SSD:      read_data = {20'd0, ssd_q};
                SEL_SYSTICK:  read_data = systick;
`ifdef TIMER_PRESCALE_EN
                SEL_PRESCALE: read_data = {16'd0, prescale};
`endif
                default:      read_data = '0;
            endcase
        end
    end

    assign IRQ = tcon[2];
    assign led = led_q;
    assign ssd = ssd_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// Self-checking bench for timer_peripheral: directed scenarios plus randomized bus traffic
// compared against a table-driven register-file reference model.
module tb_timer_peripheral;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef TIMER_PRESCALE_EN
    localparam int NREG = 7;
`else
    localparam int NREG = 6;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        hit;
    logic        IRQ;
    logic [7:0]  led;
    logic [11:0] ssd;

    timer_peripheral #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .write_data(write_data), .read_data(read_data),
        .hit(hit), .IRQ(IRQ), .led(led), .ssd(ssd)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    // Reference model: index 0 TH, 1 TL, 2 TCON, 3 LED, 4 SSD, 5 SYSTICK, 6 PRESCALE
    logic [31:0] m_reg [0:NREG-1];
    logic [15:0] m_div;
    logic [31:0] last_rd;
    logic        last_hit;
    logic        last_irq;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int idx);
        case (idx)
            0, 1:    return 32'hFFFF_FFFF;
            2:       return 32'h0000_0007;
            3:       return 32'h0000_00FF;
            4:       return 32'h0000_0FFF;
            6:       return 32'h0000_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int m_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off % 4 != 0 || off >= NREG * 4) return -1;
        return int'(off / 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_div = '0;
    endtask

    task automatic model_step(input logic mw, input int idx, input logic [31:0] wd);
        logic [31:0] n [0:NREG-1];
        logic        wr;
        logic        tick;
        wr = mw && (idx >= 0);
        for (int i = 0; i < NREG; i++) n[i] = m_reg[i];
        tick = m_reg[2][0];
`ifdef TIMER_PRESCALE_EN
        if (m_reg[2][0]) begin
            tick  = (32'(m_div) == m_reg[6]);
            m_div = tick ? 16'd0 : m_div + 16'd1;
        end else begin
            m_div = '0;
        end
        if (wr && idx == 6) m_div = '0;
`endif
        if (tick && !(wr && idx == 1)) begin
            if (m_reg[1] == 32'hFFFF_FFFF) begin
                n[1] = m_reg[0];
                if (m_reg[2][1]) n[2] = m_reg[2] | 32'd4;
            end else begin
                n[1] = m_reg[1] + 32'd1;
            end
        end
        n[5] = m_reg[5] + 32'd1;
        if (wr && idx != 5) n[idx] = wd & wmask(idx);
        for (int i = 0; i < NREG; i++) m_reg[i] = n[i];
    endtask

    task automatic cycle(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd);
        int idx;
        reset = 1'b0; MemRead = mr; MemWrite = mw; address = a; write_data = wd;
        idx = m_index(a);
        #3;
        check_val("hit", 32'(hit), 32'(idx >= 0));
        check_val("read_data", read_data, (mr && idx >= 0) ? m_reg[idx] : 32'h0);
        check_val("irq", 32'(IRQ), 32'(m_reg[2][2]));
        check_val("led", 32'(led), m_reg[3]);
        check_val("ssd", 32'(ssd), m_reg[4]);
        last_rd = read_data; last_hit = hit; last_irq = IRQ;
        @(posedge clk);
        model_step(mw, idx, wd);
        #1;
    endtask

    task automatic do_reset(input int unsigned cycles);
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b1;
        address = BASE + 32'h0C; write_data = 32'hFF;
        for (int unsigned i = 0; i < cycles; i++) @(posedge clk);
        model_reset();
        #1;
    endtask

    initial begin
        logic [31:0] offs [0:11];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                 32'h18, 32'h1C, 32'h20, 32'h02, 32'h11, 32'h1000};
        model_reset();
        #1;
        do_reset(2);

        // Reset and free-running tick
        cycle(1, 0, BASE + 32'h14, 0); check_val("systick0", last_rd, 32'd0);
        cycle(1, 0, BASE + 32'h14, 0); check_val("systick1", last_rd, 32'd1);
        cycle(1, 0, BASE + 32'h14, 0); check_val("systick2", last_rd, 32'd2);
        cycle(1, 0, BASE + 32'h0C, 0); check_val("led_rst", last_rd, 32'd0);

        // Reload with interrupt
        cycle(0, 1, BASE + 32'h00, 32'hFFFF_FFFC);
        cycle(0, 1, BASE + 32'h04, 32'hFFFF_FFFE);
        cycle(0, 1, BASE + 32'h08, 32'h3);
        cycle(1, 0, BASE + 32'h04, 0); check_val("tl_fe", last_rd, 32'hFFFF_FFFE);
        cycle(1, 0, BASE + 32'h04, 0); check_val("tl_ff", last_rd, 32'hFFFF_FFFF);
        cycle(1, 0, BASE + 32'h04, 0); check_val("tl_reload", last_rd, 32'hFFFF_FFFC);
        check_val("irq_set", 32'(last_irq), 32'd1);
        cycle(0, 1, BASE + 32'h08, 32'h3);
        check_val("irq_held", 32'(last_irq), 32'd1);
        cycle(1, 0, BASE + 32'h08, 0); check_val("tcon_clr", last_rd, 32'd3);
        check_val("irq_clr", 32'(last_irq), 32'd0);

        // Masked interrupt
        cycle(0, 1, BASE + 32'h08, 32'h0);
        cycle(0, 1, BASE + 32'h04, 32'hFFFF_FFFF);
        cycle(0, 1, BASE + 32'h08, 32'h1);
        cycle(1, 0, BASE + 32'h04, 0); check_val("m_tl_ff", last_rd, 32'hFFFF_FFFF);
        cycle(1, 0, BASE + 32'h04, 0); check_val("m_reload", last_rd, 32'hFFFF_FFFC);
        cycle(1, 0, BASE + 32'h08, 0); check_val("m_tcon", last_rd, 32'd1);
        check_val("m_irq", 32'(last_irq), 32'd0);

        // Store to TL on the overflow cycle
        cycle(0, 1, BASE + 32'h08, 32'h0);
        cycle(0, 1, BASE + 32'h04, 32'hFFFF_FFFF);
        cycle(0, 1, BASE + 32'h08, 32'h3);
        cycle(0, 1, BASE + 32'h04, 32'd5);
        cycle(1, 0, BASE + 32'h04, 0); check_val("col_tl", last_rd, 32'd5);
        check_val("col_irq", 32'(last_irq), 32'd0);
        cycle(1, 0, BASE + 32'h08, 0); check_val("col_tcon", last_rd, 32'd3);

        // Decode
        cycle(0, 1, BASE + 32'h10, 32'hFFFF_FABC);
        cycle(1, 0, BASE + 32'h10, 0); check_val("ssd_rd", last_rd, 32'h0000_0ABC);
        check_val("ssd_pin", 32'(ssd), 32'h0000_0ABC);
        cycle(1, 0, BASE + 32'h20, 0); check_val("unmap20_rd", last_rd, 32'd0);
        check_val("unmap20_hit", 32'(last_hit), 32'd0);
        cycle(1, 0, BASE + 32'h12, 0); check_val("unalign_rd", last_rd, 32'd0);
        check_val("unalign_hit", 32'(last_hit), 32'd0);
        cycle(0, 1, BASE + 32'h14, 32'h1234_5678);
        cycle(1, 1, BASE + 32'h0C, 32'h5A);
        cycle(1, 0, BASE + 32'h14, 0);

`ifdef TIMER_PRESCALE_EN
        cycle(0, 1, BASE + 32'h08, 32'h0);
        cycle(0, 1, BASE + 32'h04, 32'h0);
        cycle(0, 1, BASE + 32'h18, 32'h3);
        cycle(0, 1, BASE + 32'h08, 32'h1);
        for (int i = 0; i < 4; i++) cycle(0, 0, BASE, 0);
        cycle(1, 0, BASE + 32'h04, 0); check_val("ps_tl1", last_rd, 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 0, BASE, 0);
        cycle(1, 0, BASE + 32'h04, 0); check_val("ps_tl2", last_rd, 32'd2);
        cycle(0, 1, BASE + 32'h18, 32'h0);
`endif

        // Randomized traffic, biased toward timer wraps and TCON enables
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            logic [31:0] off;
            logic [31:0] wd;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset($urandom_range(1, 2));
            end else begin
                off = offs[$urandom_range(0, 11)];
                wd  = $urandom;
                if (off == 32'h04 && $urandom_range(0, 3) != 0) wd = 32'hFFFF_FFF0 | (wd & 32'hF);
                if (off == 32'h08 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
                if (off == 32'h18) wd = wd & 32'hFFF3_0003;
                cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), BASE + off, wd);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
